// File: rtl/btb_table_if.sv
// Lookup and update bundle for the branch target buffer.
// The master drives PCs, updates and clear; the slave (the table) returns predictions and status.
interface btb_table_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              clear;
  logic [ADDR_W-1:0] lookup_pc;
  logic              hit;
  logic              predict_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_ready;
  logic              mispredict;
  logic              busy;

  modport master (
    output clear, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  hit, predict_taken, pred_target, upd_ready, mispredict, busy
  );

  modport slave (
    input  clear, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output hit, predict_taken, pred_target, upd_ready, mispredict, busy
  );
endinterface

// File: rtl/btb_table.sv
// Fully associative branch target buffer with 2-bit counters, round-robin replacement
// and a one-entry-per-cycle clear sweep.
module btb_table #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TAG_W   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  btb_table_if.slave  bus
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_CLEARING = 1'b1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [IDX_W-1:0]   r_victim_ptr;
  logic [IDX_W-1:0]   r_clr_idx;
  logic               r_state;
  logic               r_mispredict;

  logic [TAG_W-1:0]   w_lk_tag;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_lk_match;
  logic [IDX_W-1:0]   w_lk_idx;
  logic               w_up_match;
  logic [IDX_W-1:0]   w_up_idx;
  logic               w_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_alloc_idx;
  logic [1:0]         w_up_ctr;
  logic               w_idle;
  logic               w_accept;
  logic               w_unused_pc_lo;

  assign w_lk_tag = bus.lookup_pc[ADDR_W-1 -: TAG_W];
  assign w_up_tag = bus.upd_pc[ADDR_W-1 -: TAG_W];
  assign w_unused_pc_lo = ^{bus.lookup_pc[ADDR_W-TAG_W-1:0], bus.upd_pc[ADDR_W-TAG_W-1:0]};

  // Tags are unique among valid entries, so at most one match per search.
  always_comb begin
    w_lk_match = 1'b0;
    w_lk_idx   = '0;
    w_up_match = 1'b0;
    w_up_idx   = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[IDX_W'(i)] && (r_tag[IDX_W'(i)] == w_lk_tag)) begin
        w_lk_match = 1'b1;
        w_lk_idx   = IDX_W'(i);
      end
      if (r_valid[IDX_W'(i)] && (r_tag[IDX_W'(i)] == w_up_tag)) begin
        w_up_match = 1'b1;
        w_up_idx   = IDX_W'(i);
      end
      if (!r_valid[IDX_W'(i)] && !w_free) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign w_alloc_idx = w_free ? w_free_idx : r_victim_ptr;
  assign w_up_ctr    = r_ctr[w_up_idx];
  assign w_accept    = w_idle && bus.upd_valid && !bus.clear;

  assign bus.hit           = w_lk_match && w_idle;
  assign bus.predict_taken = bus.hit ? r_ctr[w_lk_idx][1] : 1'b0;
  assign bus.pred_target   = bus.hit ? r_target[w_lk_idx] : '0;
  assign bus.upd_ready     = w_idle;
  assign bus.busy          = !w_idle;
  assign bus.mispredict    = r_mispredict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_victim_ptr <= '0;
      r_clr_idx    <= '0;
      r_state      <= ST_IDLE;
      r_mispredict <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[IDX_W'(i)]    <= '0;
        r_target[IDX_W'(i)] <= '0;
        r_ctr[IDX_W'(i)]    <= 2'b01;
      end
    end else begin
      r_mispredict <= 1'b0;
      if (r_state == ST_CLEARING) begin
        r_valid[r_clr_idx] <= 1'b0;
        if (bus.clear) begin
          r_clr_idx <= '0;
        end else if (r_clr_idx == LAST_IDX) begin
          r_clr_idx <= '0;
          r_state   <= ST_IDLE;
        end else begin
          r_clr_idx <= r_clr_idx + 1'b1;
        end
      end else if (bus.clear) begin
        r_clr_idx <= '0;
        r_state   <= ST_CLEARING;
      end else if (w_accept) begin
        if (w_up_match) begin
          r_mispredict <= (bus.upd_taken != w_up_ctr[1]);
          if (bus.upd_taken) begin
            r_target[w_up_idx] <= bus.upd_target;
            if (w_up_ctr != 2'b11) r_ctr[w_up_idx] <= w_up_ctr + 2'b01;
          end else if (w_up_ctr != 2'b00) begin
            r_ctr[w_up_idx] <= w_up_ctr - 2'b01;
          end
        end else if (bus.upd_taken) begin
          r_mispredict          <= 1'b1;
          r_valid[w_alloc_idx]  <= 1'b1;
          r_tag[w_alloc_idx]    <= w_up_tag;
          r_target[w_alloc_idx] <= bus.upd_target;
          r_ctr[w_alloc_idx]    <= 2'b10;
          if (!w_free) r_victim_ptr <= r_victim_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_table.sv
// Self-checking bench for btb_table: directed scenarios plus randomized traffic
// compared against a table-level reference model.
module tb_btb_table;
  localparam int ENT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  btb_table_if #(.ADDR_W(16)) bus ();

  btb_table #(.ENTRIES(ENT), .ADDR_W(16), .TAG_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit [10:0]   tag;
    bit [15:0]   tgt;
    int          ctr;
  } ent_t;

  ent_t m_tbl [ENT];
  int   m_vptr;
  int   m_sweep;  // clearing cycles still to come; 0 means idle
  bit   m_misp;

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) m_tbl[i] = '{v: 0, tag: 0, tgt: 0, ctr: 1};
    m_vptr  = 0;
    m_sweep = 0;
    m_misp  = 0;
  endfunction

  function automatic void m_look(input bit [15:0] pc, output bit h, output bit pt,
                                 output bit [15:0] t);
    h = 0; pt = 0; t = 0;
    if (m_sweep == 0)
      for (int i = 0; i < ENT; i++)
        if (m_tbl[i].v && m_tbl[i].tag == pc[15:5]) begin
          h = 1; pt = (m_tbl[i].ctr >= 2); t = m_tbl[i].tgt;
        end
  endfunction

  function automatic void m_edge(input bit clr, input bit uv, input bit [15:0] pc,
                                 input bit tk, input bit [15:0] tg);
    int hit_i;
    int slot;
    m_misp = 0;
    if (m_sweep > 0) begin
      m_tbl[ENT - m_sweep].v = 0;
      m_sweep = clr ? ENT : m_sweep - 1;
    end else if (clr) begin
      m_sweep = ENT;
    end else if (uv) begin
      hit_i = -1;
      for (int i = 0; i < ENT; i++) if (m_tbl[i].v && m_tbl[i].tag == pc[15:5]) hit_i = i;
      if (hit_i >= 0) begin
        m_misp = (tk != (m_tbl[hit_i].ctr >= 2));
        if (tk) begin
          m_tbl[hit_i].ctr = (m_tbl[hit_i].ctr == 3) ? 3 : m_tbl[hit_i].ctr + 1;
          m_tbl[hit_i].tgt = tg;
        end else begin
          m_tbl[hit_i].ctr = (m_tbl[hit_i].ctr == 0) ? 0 : m_tbl[hit_i].ctr - 1;
        end
      end else if (tk) begin
        m_misp = 1;
        slot = -1;
        for (int i = ENT - 1; i >= 0; i--) if (!m_tbl[i].v) slot = i;
        if (slot < 0) begin
          slot = m_vptr;
          m_vptr = (m_vptr + 1) % ENT;
        end
        m_tbl[slot] = '{v: 1, tag: pc[15:5], tgt: tg, ctr: 2};
      end
    end
  endfunction

  // One clock: present inputs, take the edge, update the model, release inputs.
  task automatic tick(input bit clr, input bit uv, input bit [15:0] pc, input bit tk,
                      input bit [15:0] tg);
    bus.clear = clr; bus.upd_valid = uv; bus.upd_pc = pc;
    bus.upd_taken = tk; bus.upd_target = tg;
    @(posedge clk);
    m_edge(clr, uv, pc, tk, tg);
    #1;
    bus.clear = 0; bus.upd_valid = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    m_reset();
    #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m_reset();
    bus.lookup_pc = 16'h1234;
    #12;
    n_checks += 5;
    if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
    if (bus.predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_pt got=%b exp=0", bus.predict_taken);
    end
    if (bus.pred_target !== 16'h0) begin
      n_fail++; $display("FAIL reset_tgt got=%h exp=0000", bus.pred_target);
    end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.upd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.upd_ready);
    end
    #1 rst_n = 1;
    @(posedge clk); #1;
    n_checks += 3;
    if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL post_reset_hit got=%b exp=0", bus.hit); end
    if (bus.mispredict !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_misp got=%b exp=0", bus.mispredict);
    end
    if (bus.upd_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready got=%b exp=1", bus.upd_ready);
    end
  endtask

  task automatic test_alloc_lookup();
    bus.lookup_pc = 16'h1234;
    bus.clear = 0; bus.upd_valid = 1; bus.upd_pc = 16'h1234;
    bus.upd_taken = 1; bus.upd_target = 16'h2000;
    #1;
    n_checks++;
    if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_hit got=%b exp=0", bus.hit); end
    tick(0, 1, 16'h1234, 1, 16'h2000);
    n_checks += 4;
    if (bus.mispredict !== 1'b1) begin
      n_fail++; $display("FAIL alloc_misp got=%b exp=1", bus.mispredict);
    end
    if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit got=%b exp=1", bus.hit); end
    if (bus.predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL alloc_pt got=%b exp=1", bus.predict_taken);
    end
    if (bus.pred_target !== 16'h2000) begin
      n_fail++; $display("FAIL alloc_tgt got=%h exp=2000", bus.pred_target);
    end
  endtask

  task automatic test_counter();
    tick(0, 1, 16'h1234, 0, 16'h0bad);
    n_checks += 2;
    if (bus.mispredict !== 1'b1) begin
      n_fail++; $display("FAIL nt1_misp got=%b exp=1", bus.mispredict);
    end
    if (bus.predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL nt1_pt got=%b exp=0", bus.predict_taken);
    end
    tick(0, 1, 16'h1234, 0, 16'h0bad);
    n_checks += 3;
    if (bus.mispredict !== 1'b0) begin
      n_fail++; $display("FAIL nt2_misp got=%b exp=0", bus.mispredict);
    end
    if (bus.predict_taken !== 1'b0 || bus.hit !== 1'b1) begin
      n_fail++; $display("FAIL nt2_pt got=%b/%b exp=0/1", bus.predict_taken, bus.hit);
    end
    if (bus.pred_target !== 16'h2000) begin
      n_fail++; $display("FAIL nt_keep_tgt got=%h exp=2000", bus.pred_target);
    end
    // 00 needs two taken updates before predicting taken again
    tick(0, 1, 16'h1234, 1, 16'h2222);
    n_checks++;
    if (bus.predict_taken !== 1'b0 || bus.mispredict !== 1'b1) begin
      n_fail++; $display("FAIL t1_pt_misp got=%b/%b exp=0/1", bus.predict_taken, bus.mispredict);
    end
  endtask

  task automatic test_replace();
    bit h, pt;
    bit [15:0] t;
    do_reset();
    for (int i = 1; i <= 5; i++) tick(0, 1, 16'(i * 16'h1000), 1, 16'(i * 16'h0111));
    n_checks += 2;
    if (bus.mispredict !== 1'b1) begin
      n_fail++; $display("FAIL fifth_misp got=%b exp=1", bus.mispredict);
    end
    bus.lookup_pc = 16'h1000; #1;
    if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL evict_first got=%b exp=0", bus.hit); end
    tick(0, 1, 16'h6000, 1, 16'h0666);
    for (int i = 1; i <= 6; i++) begin
      bus.lookup_pc = 16'(i * 16'h1000); #1;
      m_look(bus.lookup_pc, h, pt, t);
      n_checks++;
      if (bus.hit !== h || bus.pred_target !== t) begin
        n_fail++;
        $display("FAIL replace_pc%0d got=%b/%h exp=%b/%h", i, bus.hit, bus.pred_target, h, t);
      end
    end
  endtask

  task automatic test_clear();
    int busy_n;
    bus.lookup_pc = 16'h3000;
    tick(1, 0, 0, 0, 0);
    busy_n = 0;
    for (int c = 0; c < 8 && bus.busy === 1'b1; c++) begin
      busy_n++;
      n_checks++;
      if (bus.upd_ready !== 1'b0 || bus.hit !== 1'b0) begin
        n_fail++; $display("FAIL sweep_c%0d ready/hit got=%b/%b exp=0/0", c, bus.upd_ready, bus.hit);
      end
      tick(0, 1, 16'h7000, 1, 16'h0777);
    end
    n_checks++;
    if (busy_n != ENT) begin n_fail++; $display("FAIL sweep_len got=%0d exp=%0d", busy_n, ENT); end
    for (int i = 1; i <= 7; i++) begin
      bus.lookup_pc = 16'(i * 16'h1000); #1;
      n_checks++;
      if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL cleared_pc%0d got=%b exp=0", i, bus.hit); end
    end
  endtask

  task automatic test_clear_restart();
    int busy_n;
    for (int i = 1; i <= 4; i++) tick(0, 1, 16'(i * 16'h1100), 1, 16'h0abc);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    busy_n = 0;
    for (int c = 0; c < 10 && bus.busy === 1'b1; c++) begin
      busy_n++;
      tick(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (busy_n != ENT) begin n_fail++; $display("FAIL restart_len got=%0d exp=%0d", busy_n, ENT); end
    tick(1, 1, 16'h5550, 1, 16'h0555);
    n_checks++;
    if (bus.mispredict !== 1'b0) begin
      n_fail++; $display("FAIL drop_misp got=%b exp=0", bus.mispredict);
    end
    for (int c = 0; c < ENT; c++) tick(0, 0, 0, 0, 0);
    bus.lookup_pc = 16'h5550; #1;
    n_checks++;
    if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL drop_hit got=%b exp=0", bus.hit); end
  endtask

  task automatic test_reset_mid_sweep();
    tick(0, 1, 16'h4400, 1, 16'h0440);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    m_reset();
    #1;
    n_checks += 2;
    if (bus.busy !== 1'b0 || bus.upd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_sweep busy/ready got=%b/%b exp=0/1", bus.busy, bus.upd_ready);
    end
    bus.lookup_pc = 16'h4400; #1;
    if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL rst_sweep_hit got=%b exp=0", bus.hit); end
    #1 rst_n = 1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.hit !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_sweep_after hit/busy got=%b/%b exp=0/0", bus.hit, bus.busy);
    end
  endtask

  task automatic test_random();
    bit h, pt;
    bit [15:0] t;
    bit clr, uv, tk;
    bit [15:0] pc, tg;
    for (int n = 0; n < 400; n++) begin
      bus.lookup_pc = {11'($urandom_range(1, 6)), 5'($urandom)};
      #1;
      m_look(bus.lookup_pc, h, pt, t);
      n_checks++;
      if (bus.hit !== h || bus.predict_taken !== pt || bus.pred_target !== t ||
          bus.busy !== (m_sweep > 0) || bus.upd_ready !== (m_sweep == 0)) begin
        n_fail++;
        $display("FAIL rand_look n=%0d got=%b%b/%h b%b r%b exp=%b%b/%h b%b", n, bus.hit,
                 bus.predict_taken, bus.pred_target, bus.busy, bus.upd_ready, h, pt, t,
                 m_sweep > 0);
      end
      clr = ($urandom_range(0, 39) == 0);
      uv  = 1'($urandom);
      tk  = ($urandom_range(0, 3) != 0);
      pc  = {11'($urandom_range(1, 6)), 5'($urandom)};
      tg  = 16'($urandom);
      tick(clr, uv, pc, tk, tg);
      n_checks++;
      if (bus.mispredict !== m_misp) begin
        n_fail++; $display("FAIL rand_misp n=%0d got=%b exp=%b", n, bus.mispredict, m_misp);
      end
    end
  endtask

  initial begin
    clk = 0;
    n_checks = 0;
    n_fail = 0;
    bus.clear = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
    bus.upd_target = 0; bus.lookup_pc = 0;
    test_reset();
    test_alloc_lookup();
    test_counter();
    test_replace();
    test_clear();
    test_clear_restart();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
